lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
Parametrised load/store unit that replaces the fixed single-word data port handshake of the processor core. It supports byte, half, word and (XLEN=64) double accesses with sign/zero extension and byte-lane steering. It runs a request/valid handshake with data memory, detects misalignment, and reports completion to the core's control FSM. It sits between the core (ALU address, register-file store data and load writeback) and the data memory port.

Parameters:
XLEN, 32, data/address width; legal values are 32 or 64.
TIMEOUT_CYCLES, 16, cycles data_req may stay high without data_valid before an error; used only with LSU_TIMEOUT_EN.

Ports:
CLK  input  1  clock, rising edge.
RES  input  1  asynchronous active-low reset.
START  input  1  one-cycle request from the core; sampled only in IDLE.
IS_STORE  input  1  1 = store, 0 = load; sampled with START.
FUNCT3  input  3  RISC-V size/sign: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only).
ADDR  input  XLEN  byte address; sampled with START.
WDATA  input  XLEN  store data in the low bits; sampled with START.
BUSY  output  1  high from the cycle after START is accepted until the DONE/ERR cycle inclusive.
DONE  output  1  one-cycle pulse on successful completion.
ERR  output  1  one-cycle pulse on misalignment, illegal FUNCT3 or timeout.
RDATA  output  XLEN  extended load result; valid while DONE=1, held until the next accepted START.
data_req  output  1  memory request.
data_write_enable  output  1  store qualifier; valid only while data_req=1.
data_adr  output  XLEN  address aligned to XLEN/8 bytes.
data_write  output  XLEN  store data shifted to the addressed lanes.
data_byte_en  output  XLEN/8  active byte lanes.
data_read  input  XLEN  full-width read word.
data_valid  input  1  memory completion; sampled only while data_req=1.

Behaviour:
- Reset (RES=0, asynchronous): state=IDLE. All outputs are 0, including RDATA and the timeout counter. A reset mid-transaction drops data_req immediately. Memory is expected to discard the request.
- States: IDLE, REQ, DONE, ERR. All outputs are registered.
- IDLE + START=1:
  - Sample IS_STORE, FUNCT3, ADDR and WDATA.
  - Misaligned access goes to ERR: H with ADDR[0]!=0; W with ADDR[1:0]!=0; D with ADDR[2:0]!=0.
  - Illegal FUNCT3 goes to ERR: 111; 011/110 when XLEN=32; any unsigned code with IS_STORE=1.
  - Otherwise go to REQ. No bus request is issued on the ERR path.
- REQ:
  - data_req=1.
  - data_adr = ADDR with the low log2(XLEN/8) bits cleared.
  - data_byte_en: size-wide contiguous ones, shifted left by the byte offset.
  - data_write = WDATA replicated or shifted to the same lanes. Unused lanes are don't-care but held stable.
  - data_write_enable = IS_STORE.
  - All memory outputs stay constant until data_valid=1.
- REQ + data_valid=1:
  - For loads, extract the addressed bytes from data_read and sign- or zero-extend them into RDATA in the same edge.
  - For stores, RDATA is unchanged.
  - Go to DONE. data_req drops in the DONE cycle.
- DONE: DONE=1 for one cycle, then IDLE.
- ERR: ERR=1 for one cycle, then IDLE.
- Latency from START to DONE is 2 + wait cycles. Zero-wait memory (data_valid high in the first REQ cycle) gives DONE 2 cycles after START.
- START outside IDLE is ignored; no queueing.
- data_valid outside REQ is ignored.
- START in the DONE/ERR cycle is ignored. The core must re-issue it in IDLE, so back-to-back throughput is one access per 3 cycles.

Optional Feature:
Macro LSU_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on REQ entry and increments each REQ cycle without data_valid.
  - When it reaches TIMEOUT_CYCLES, go to ERR and drop data_req. data_valid in that same cycle takes priority and completes normally.
- Undefined: no counter; REQ waits indefinitely.

Test Plan:
- XLEN=32, zero-wait. LB at ADDR=0x1003 with data_read=0x80FF_1234 → data_adr=0x1000, data_byte_en=4'b1000, RDATA=0xFFFF_FF80, DONE 2 cycles after START.
- LHU at ADDR=0x2002 with data_read=0xBEEF_0000 → byte_en=4'b1100, RDATA=0x0000_BEEF. SB at 0x2001 with WDATA=0x55 → data_write_enable=1, byte_en=4'b0010, data_write[15:8]=0x55.
- LW at ADDR=0x0006 → ERR pulse the cycle after START, data_req never asserted. LD (FUNCT3=011) at XLEN=32 → ERR.
- SW at 0x10 with data_valid held low for 5 cycles → data_req and all memory outputs stable for 6 cycles, DONE on the 7th. A START pulsed mid-wait is ignored.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, data_valid never asserted → ERR after 4 REQ cycles, then IDLE. Second run: data_valid on the 4th REQ cycle → DONE, no ERR.
- Drive RES low during REQ → data_req, BUSY and RDATA are 0 immediately (asynchronous). After release, LW at 0x0 completes normally (XLEN=64 build: LD at 0x8 → byte_en=8'hFF).

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the core and the data memory port.
// Handles B/H/W (and D when XLEN=64) accesses with byte-lane steering,
// sign/zero extension of loads, misalignment and illegal-size detection.
// Optional macro LSU_TIMEOUT_EN adds a REQ-state timeout that raises ERR
// after TIMEOUT_CYCLES cycles without data_valid.
module lsu_ctrl #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                CLK,
    input  logic                RES,
    input  logic                START,
    input  logic                IS_STORE,
    input  logic [2:0]          FUNCT3,
    input  logic [XLEN-1:0]     ADDR,
    input  logic [XLEN-1:0]     WDATA,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR,
    output logic [XLEN-1:0]     RDATA,
    output logic                data_req,
    output logic                data_write_enable,
    output logic [XLEN-1:0]     data_adr,
    output logic [XLEN-1:0]     data_write,
    output logic [XLEN/8-1:0]   data_byte_en,
    input  logic [XLEN-1:0]     data_read,
    input  logic                data_valid
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);

    if ((XLEN != 32 && XLEN != 64) || TIMEOUT_CYCLES == 0) begin : g_bad_param
        $error("lsu_ctrl: XLEN must be 32 or 64 and TIMEOUT_CYCLES must be nonzero");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [2:0]        r_funct3;
    logic [OFFW-1:0]   r_off;

    logic [OFFW-1:0]   w_off;
    logic              w_illegal;
    logic              w_misalign;
    logic              w_accept;
    logic              w_timeout;
    logic [NB-1:0]     w_be_base;
    logic [XLEN-1:0]   w_rshift;
    logic [XLEN-1:0]   w_load;

    assign w_off    = ADDR[OFFW-1:0];
    assign w_accept = (r_state == S_IDLE) && START && !w_illegal && !w_misalign;

    // Decode illegal size/sign codes and natural-alignment violations of the request
    always_comb begin
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        if (FUNCT3 == 3'b111)
            w_illegal = 1'b1;
        if (XLEN == 32 && (FUNCT3 == 3'b011 || FUNCT3 == 3'b110))
            w_illegal = 1'b1;
        if (FUNCT3[2] && IS_STORE)
            w_illegal = 1'b1;
        case (FUNCT3[1:0])
            2'b01:   w_misalign = ADDR[0];
            2'b10:   w_misalign = (ADDR[1:0] != 2'b00);
            2'b11:   w_misalign = (ADDR[2:0] != 3'b000);
            default: w_misalign = 1'b0;
        endcase
    end

    // Contiguous lane mask for the access size, before shifting to the offset
    always_comb begin
        w_be_base = '0;
        case (FUNCT3[1:0])
            2'b00:   w_be_base = NB'(8'h01);
            2'b01:   w_be_base = NB'(8'h03);
            2'b10:   w_be_base = NB'(8'h0F);
            default: w_be_base = NB'(8'hFF);
        endcase
    end

    // Bring the addressed bytes down to bit 0 and extend per the latched FUNCT3
    assign w_rshift = data_read >> {r_off, 3'b000};

    always_comb begin
        w_load = w_rshift;
        case (r_funct3)
            3'b000:  w_load = XLEN'($signed(w_rshift[7:0]));
            3'b001:  w_load = XLEN'($signed(w_rshift[15:0]));
            3'b010:  w_load = XLEN'($signed(w_rshift[31:0]));
            3'b100:  w_load = XLEN'(w_rshift[7:0]);
            3'b101:  w_load = XLEN'(w_rshift[15:0]);
            3'b110:  w_load = XLEN'(w_rshift[31:0]);
            default: w_load = w_rshift;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tcnt;

    // Fires on the REQ cycle whose missing data_valid would bring the count to TIMEOUT_CYCLES
    assign w_timeout = (r_state == S_REQ) && !data_valid &&
                       (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

    // Count REQ cycles without data_valid; held at zero outside REQ
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES)
            r_tcnt <= '0;
        else if (r_state != S_REQ)
            r_tcnt <= '0;
        else if (!data_valid)
            r_tcnt <= r_tcnt + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (START)
                    w_next = (w_illegal || w_misalign) ? S_ERR : S_REQ;
            end
            S_REQ: begin
                if (data_valid)
                    w_next = S_DONE;
                else if (w_timeout)
                    w_next = S_ERR;
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Registered outputs, decoded from the next state so they align with r_state
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            BUSY              <= 1'b0;
            DONE              <= 1'b0;
            ERR               <= 1'b0;
            RDATA             <= '0;
            data_req          <= 1'b0;
            data_write_enable <= 1'b0;
            data_adr          <= '0;
            data_write        <= '0;
            data_byte_en      <= '0;
            r_funct3          <= '0;
            r_off             <= '0;
        end else begin
            BUSY     <= (w_next != S_IDLE);
            DONE     <= (w_next == S_DONE);
            ERR      <= (w_next == S_ERR);
            data_req <= (w_next == S_REQ);
            if (w_accept) begin
                data_adr          <= {ADDR[XLEN-1:OFFW], OFFW'(0)};
                data_byte_en      <= w_be_base << w_off;
                data_write        <= WDATA << {w_off, 3'b000};
                data_write_enable <= IS_STORE;
                r_funct3          <= FUNCT3;
                r_off             <= w_off;
            end else if (w_next != S_REQ) begin
                data_write_enable <= 1'b0;
            end
            if (r_state == S_REQ && data_valid && !data_write_enable)
                RDATA <= w_load;
        end
    end

endmodule
